// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic MODE_ADD = 1'b1;
   localparam logic MODE_SUB = 1'b0;

   // Digit counter width; one spare bit keeps the terminal count representable.
   function automatic int cnt_width(input int width, input int digit);
      return $clog2(width / digit) + 1;
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder slice; msb_cin exists only with ADDSUB_FLAGS_EN.
module addsub_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout
`ifdef ADDSUB_FLAGS_EN
   ,
   output logic             msb_cin
`endif
);

   always_comb begin : ripple
      logic c;
      s = '0;
      c = cin;
`ifdef ADDSUB_FLAGS_EN
      msb_cin = 1'b0;
`endif
      for (int i = 0; i < DIGIT; i++) begin
`ifdef ADDSUB_FLAGS_EN
         // The last iteration leaves the carry entering the top bit.
         msb_cin = c;
`endif
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor with valid/ready handshake.
// Optional ovf/zero flags when ADDSUB_FLAGS_EN is defined.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             a_ns,
   output logic             ready,
   output logic             res_valid,
   input  logic             res_ack,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef ADDSUB_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(WIDTH, DIGIT);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t                 state, state_next;
   logic [WIDTH-1:0]       a_sh, b_sh;
   logic                   carry;
   logic [CW-1:0]          cnt;
   logic [DIGIT-1:0]       sum_d;
   logic                   carry_d;
   logic                   last_digit;
   logic [WIDTH+DIGIT-1:0] res_cat;
`ifdef ADDSUB_FLAGS_EN
   logic                   msb_cin_d;
`endif

   assign last_digit = (cnt == CW'(NDIG - 1));
   assign res_cat    = {sum_d, result};

   // NOTE: every flop is written with <= so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: defaulting state_next first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)      state_next = RUN;
         RUN:     if (last_digit) state_next = DONE;
         DONE:    if (res_ack)    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_comb begin
      ready     = (state == IDLE);
      res_valid = (state == DONE);
   end

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .cin  (carry),
      .s    (sum_d),
      .cout (carry_d)
`ifdef ADDSUB_FLAGS_EN
      ,
      .msb_cin (msb_cin_d)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
         ovf    <= 1'b0;
         zero   <= 1'b0;
`endif
      end else if (state == IDLE && start) begin
         // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
         a_sh  <= a_in;
         b_sh  <= (a_ns == MODE_ADD) ? b_in : ~b_in;
         carry <= (a_ns != MODE_ADD);
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         carry  <= carry_d;
         cnt    <= cnt + CW'(1);
         result <= res_cat[WIDTH+DIGIT-1:DIGIT];
         if (last_digit) begin
            cout <= carry_d;
`ifdef ADDSUB_FLAGS_EN
            ovf  <= msb_cin_d ^ carry_d;
            zero <= (res_cat[WIDTH+DIGIT-1:DIGIT] == '0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub in (8,1), (16,4) and (32,8) configurations.
// Flag outputs are checked when ADDSUB_FLAGS_EN is defined.
module tb_serial_addsub;
   import addsub_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  start = '0, mode = '0;
   logic [2:0]  ready, res_valid, res_ack, cout;
   logic [2:0]  ack_auto = '0, ack_man = '0, ack_rnd = '0;
   logic [7:0]  a0 = '0, b0 = '0;
   logic [15:0] a1 = '0, b1 = '0;
   logic [31:0] a2 = '0, b2 = '0;
   logic [7:0]  result0;
   logic [15:0] result1;
   logic [31:0] result2;
   logic [31:0] res_w [3];
`ifdef ADDSUB_FLAGS_EN
   logic [2:0]  ovf, zero;
`endif

   exp_t sb0[$], sb1[$], sb2[$];
   int n_pass = 0, n_total = 0;

   assign res_ack  = (ack_auto & ack_rnd) | (~ack_auto & ack_man);
   assign res_w[0] = {24'd0, result0};
   assign res_w[1] = {16'd0, result1};
   assign res_w[2] = result2;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .a_in(a0), .b_in(b0), .a_ns(mode[0]),
      .ready(ready[0]), .res_valid(res_valid[0]), .res_ack(res_ack[0]),
      .result(result0), .cout(cout[0])
`ifdef ADDSUB_FLAGS_EN
      , .ovf(ovf[0]), .zero(zero[0])
`endif
   );

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .a_in(a1), .b_in(b1), .a_ns(mode[1]),
      .ready(ready[1]), .res_valid(res_valid[1]), .res_ack(res_ack[1]),
      .result(result1), .cout(cout[1])
`ifdef ADDSUB_FLAGS_EN
      , .ovf(ovf[1]), .zero(zero[1])
`endif
   );

   serial_addsub #(.WIDTH(32), .DIGIT(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .a_in(a2), .b_in(b2), .a_ns(mode[2]),
      .ready(ready[2]), .res_valid(res_valid[2]), .res_ack(res_ack[2]),
      .result(result2), .cout(cout[2])
`ifdef ADDSUB_FLAGS_EN
      , .ovf(ovf[2]), .zero(zero[2])
`endif
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #2;
      ack_rnd = 3'($urandom);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int width_of(input int k);
      return (k == 0) ? 8 : (k == 1) ? 16 : 32;
   endfunction

   function automatic int ndig_of(input int k);
      return (k == 0) ? 8 : 4;
   endfunction

   function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
      exp_t e;
      e.res = r; e.cout = c; e.ovf = o; e.zero = z;
      return e;
   endfunction

   // Reference: plain modulo arithmetic, unsigned compare for borrow, sign rules for overflow.
   function automatic exp_t model(input int k, input logic [31:0] a, input logic [31:0] b,
                                  input logic m);
      exp_t   e;
      int     w;
      longint la, lb, mask, r;
      bit     sa, sb, sr;
      w    = width_of(k);
      la   = longint'(a);
      lb   = longint'(b);
      mask = (longint'(1) << w) - 1;
      r    = (m == MODE_ADD) ? la + lb : la - lb;
      e.res  = 32'(r & mask);
      e.cout = (m == MODE_ADD) ? (((la + lb) >> w) != 0) : (la >= lb);
      sa = ((la >> (w - 1)) & 1) != 0;
      sb = ((lb >> (w - 1)) & 1) != 0;
      sr = (((r & mask) >> (w - 1)) & 1) != 0;
      e.ovf  = (m == MODE_ADD) ? (sa == sb && sr != sa) : (sa != sb && sr != sa);
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
      case (k)
         0:       begin a0 = a[7:0];  b0 = b[7:0];  end
         1:       begin a1 = a[15:0]; b1 = b[15:0]; end
         default: begin a2 = a;       b2 = b;       end
      endcase
   endtask

   task automatic push(input int k, input exp_t e);
      case (k)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   task automatic pop(input int k, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = mk(32'd0, 1'b0, 1'b0, 1'b0);
      case (k)
         0:       if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
         1:       if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
         default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Called at posedge+1; returns at accept edge+1 with the expectation queued.
   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input exp_t e);
      int n = 0;
      while (!ready[k] && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500) check($sformatf("ready_wait%0d", k), {31'd0, ready[k]}, 32'd1);
      set_ops(k, a, b);
      mode[k]  = m;
      start[k] = 1'b1;
      @(posedge clk);
      push(k, e);
      #1;
      start[k] = 1'b0;
      set_ops(k, $urandom, $urandom);
      mode[k] = 1'($urandom_range(0, 1));
   endtask

   task automatic latency(input int k);
      int   n = 0;
      logic busy_ok = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (ready[k]) busy_ok = 1'b0;
      end while (!res_valid[k] && n < 100);
      check($sformatf("latency%0d", k), 32'(n), 32'(ndig_of(k)));
      check($sformatf("ready_low%0d", k), {31'd0, busy_ok}, 32'd1);
   endtask

   task automatic run_directed(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic m, input exp_t e);
      issue(k, a, b, m, e);
      latency(k);
      ack_man[k] = 1'b1;
      @(posedge clk);
      #1;
      ack_man[k] = 1'b0;
   endtask

   task automatic rand_op(input int k);
      logic [31:0] a, b, mask;
      logic        m;
      int          sel;
      mask = (width_of(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_of(k)) - 32'd1);
      a    = $urandom & mask;
      b    = $urandom & mask;
      sel  = $urandom_range(0, 7);
      if (sel == 0) a = 32'd0;
      if (sel == 1) a = mask;
      if (sel == 2) b = a;
      m = 1'($urandom_range(0, 1));
      issue(k, a, b, m, model(k, a, b, m));
   endtask

   // Monitor: pops one expectation per completed result transfer.
   initial forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if (rst_n && res_valid[k] && res_ack[k]) begin : mon
            exp_t e;
            bit   ok;
            pop(k, e, ok);
            check($sformatf("sb_entry%0d", k), {31'd0, ok}, 32'd1);
            if (ok) begin
               check($sformatf("result%0d", k), res_w[k], e.res);
               check($sformatf("cout%0d", k), {31'd0, cout[k]}, {31'd0, e.cout});
`ifdef ADDSUB_FLAGS_EN
               check($sformatf("ovf%0d", k), {31'd0, ovf[k]}, {31'd0, e.ovf});
               check($sformatf("zero%0d", k), {31'd0, zero[k]}, {31'd0, e.zero});
`endif
            end
         end
      end
   end

   initial begin : main
      logic [31:0] held;
      logic        stable;
      int          n;

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ready%0d", k), {31'd0, ready[k]}, 32'd1);
         check($sformatf("rst_valid%0d", k), {31'd0, res_valid[k]}, 32'd0);
         check($sformatf("rst_result%0d", k), res_w[k], 32'd0);
         check($sformatf("rst_cout%0d", k), {31'd0, cout[k]}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
         check($sformatf("rst_flags%0d", k), {30'd0, ovf[k], zero[k]}, 32'd0);
`endif
      end
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic add/sub cases, including wrap and borrow boundaries.
      run_directed(0, 32'h5A, 32'h33, MODE_ADD, mk(32'h8D, 1'b0, 1'b1, 1'b0));
      run_directed(0, 32'hFF, 32'h01, MODE_ADD, mk(32'h00, 1'b1, 1'b0, 1'b1));
      run_directed(0, 32'h10, 32'h20, MODE_SUB, mk(32'hF0, 1'b0, 1'b0, 1'b0));
      run_directed(0, 32'h20, 32'h10, MODE_SUB, mk(32'h10, 1'b1, 1'b0, 1'b0));

      // Handshake: start during RUN and DONE ignored, result held while unacked.
      issue(0, 32'h3C, 32'h0F, MODE_ADD, mk(32'h4B, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      start[0] = 1'b1;
      set_ops(0, 32'hFF, 32'hFF);
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      n = 0;
      while (!res_valid[0] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("valid_after_run_start", {31'd0, res_valid[0]}, 32'd1);
      held     = res_w[0];
      stable   = 1'b1;
      start[0] = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (!res_valid[0] || ready[0] || res_w[0] != held) stable = 1'b0;
      end
      check("hold_stable", {31'd0, stable}, 32'd1);
      check("hold_value", held, 32'h4B);
      ack_man[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0]   = 1'b0;
      ack_man[0] = 1'b0;
      check("ack_start_idle", {31'd0, ready[0]}, 32'd1);
      check("ack_start_valid", {31'd0, res_valid[0]}, 32'd0);
      run_directed(0, 32'hC8, 32'h64, MODE_SUB, mk(32'h64, 1'b1, 1'b1, 1'b0));

      // Asynchronous reset in the middle of RUN.
      issue(0, 32'hAA, 32'h55, MODE_ADD, mk(32'hFF, 1'b0, 1'b0, 1'b0));
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", {31'd0, ready[0]}, 32'd1);
      check("arst_valid", {31'd0, res_valid[0]}, 32'd0);
      check("arst_result", res_w[0], 32'd0);
      check("arst_cout", {31'd0, cout[0]}, 32'd0);
      sb0.delete();
      sb1.delete();
      sb2.delete();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_directed(0, 32'h01, 32'h01, MODE_ADD, mk(32'h02, 1'b0, 1'b0, 1'b0));

      // Wider configurations.
      run_directed(1, 32'h1234, 32'h0FFF, MODE_SUB, mk(32'h0235, 1'b1, 1'b0, 1'b0));
      run_directed(2, 32'hFFFF_FFFF, 32'h1, MODE_ADD, mk(32'h0, 1'b1, 1'b0, 1'b1));

      // Signed overflow and zero boundaries.
      run_directed(0, 32'h7F, 32'h01, MODE_ADD, mk(32'h80, 1'b0, 1'b1, 1'b0));
      run_directed(0, 32'h80, 32'h01, MODE_SUB, mk(32'h7F, 1'b1, 1'b1, 1'b0));
      run_directed(0, 32'h05, 32'h05, MODE_SUB, mk(32'h00, 1'b1, 1'b0, 1'b1));

      // Randomised traffic on all three configurations with random backpressure.
      ack_auto = 3'b111;
      fork
         for (int i = 0; i < 1000; i++) rand_op(0);
         for (int i = 0; i < 1000; i++) rand_op(1);
         for (int i = 0; i < 1000; i++) rand_op(2);
      join
      n = 0;
      while ((sb0.size() + sb1.size() + sb2.size()) != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
